// File: rtl/shift_add_mult8_pkg.sv
// Shared definitions for the shift-and-add multiplier: operand width,
// iteration count and the controller state encoding.
package shift_add_mult8_pkg;

  localparam int MUL_W     = 8;
  localparam int MUL_ITERS = 8;

  localparam logic [2:0] CNT_LAST = 3'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mult8_cla.sv
// eightbitCLA: 8-bit carry-lookahead adder built from two 4-bit lookahead
// groups; the high group's carry-in is the low group's carry-out.
//   A, B      : 8-bit addends
//   Carryin   : carry into bit 0
//   Sum       : 8-bit sum
//   Carryout  : carry out of bit 7
module eightbitCLA (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Carryin,
  output logic [7:0] Sum,
  output logic       Carryout
);

  // Returns {c4,c3,c2,c1,c0}; every carry is a flat sum of products of g/p.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [4:0] w_c_lo;
  logic [4:0] w_c_hi;

  assign w_g    = A & B;
  assign w_p    = A ^ B;
  assign w_c_lo = cla4(w_g[3:0], w_p[3:0], Carryin);
  assign w_c_hi = cla4(w_g[7:4], w_p[7:4], w_c_lo[4]);

  assign Sum      = w_p ^ {w_c_hi[3:0], w_c_lo[3:0]};
  assign Carryout = w_c_hi[4];

endmodule

// File: rtl/shift_add_mult8.sv
// shift_add_mult8: sequential 8x8 unsigned multiplier, one shift-and-add
// iteration per cycle through an 8-bit carry-lookahead adder.
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset (aborts any operation)
//   start        : request; honoured only in IDLE or DONE
//   multiplicand : operand A, captured on accept
//   multiplier   : operand B, captured on accept
//   busy         : high while iterating
//   done         : one-cycle pulse when product updates
//   product      : A*B of the last completed operation
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one shift-and-add per cycle, 8 cycles
// DONE    | product just updated; start here chains the next operation
module shift_add_mult8
  import shift_add_mult8_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MUL_W-1:0]   multiplicand,
  input  logic [MUL_W-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*MUL_W-1:0] product
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MUL_W-1:0]   r_acc_hi;
  logic [MUL_W-1:0]   r_acc_lo;
  logic [MUL_W-1:0]   r_mcand;
  logic [2:0]         r_cnt;
  logic [2*MUL_W-1:0] r_product;

  logic [MUL_W-1:0]   w_sum;
  logic               w_cout;
  logic               w_accept;
  logic               w_last;
  logic [2*MUL_W-1:0] w_shifted;

  eightbitCLA u_cla (
    .A        (r_acc_hi),
    .B        (r_mcand),
    .Carryin  (1'b0),
    .Sum      (w_sum),
    .Carryout (w_cout)
  );

  // 17-bit right shift of {carry, acc_hi, acc_lo}; the add's carry lands in bit 15.
  assign w_shifted = r_acc_lo[0] ? {w_cout, w_sum, r_acc_lo[MUL_W-1:1]}
                                 : {1'b0, r_acc_hi, r_acc_lo[MUL_W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_DONE;
          w_last      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_mcand   <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand  <= multiplicand;
      r_acc_hi <= '0;
      r_acc_lo <= multiplier;
      r_cnt    <= '0;
    end else if (r_state == ST_RUN) begin
      {r_acc_hi, r_acc_lo} <= w_shifted;
      r_cnt                <= r_cnt + 3'd1;
      if (w_last) r_product <= w_shifted;
    end
  end

  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_shift_add_mult8.sv
module tb_shift_add_mult8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  shift_add_mult8 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Behavioural model: an accepted request finishes exactly 8 edges later
  // with the arithmetic product; requests are only taken when not iterating.
  bit          m_valid = 0;
  int          m_left = 0;
  bit          m_done = 0;
  logic [15:0] m_prod = '0;
  logic [15:0] m_pend = '0;
  int          m_accepts = 0;
  int          dut_dones = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_valid = 1;
      m_left  = 0;
      m_done  = 0;
      m_prod  = '0;
    end else if (m_left == 0 && start) begin
      m_pend = 16'(multiplicand) * 16'(multiplier);
      m_left = 8;
      m_done = 0;
      m_accepts++;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_left == 0) m_prod = m_pend;
    end else begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {15'd0, busy}, {15'd0, (m_left > 0)});
      check("done", {15'd0, done}, {15'd0, m_done});
      check("product", product, m_prod);
      if (done === 1'b1) dut_dones++;
    end
  end

  task automatic wait_done(input string nm, output int n_busy, output int at_cyc);
    bit seen = 0;
    n_busy = 0;
    at_cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy) n_busy++;
      if (done) begin
        seen   = 1;
        at_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check({nm, " done seen"}, {15'd0, seen}, 16'd1);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                    input string nm);
    int nb, t;
    @(negedge clk);
    start = 1; multiplicand = a; multiplier = b;
    @(negedge clk);
    start = 0;
    wait_done(nm, nb, t);
    check({nm, " busy cycles"}, 16'(nb), 16'd8);
    check({nm, " product"}, product, exp);
    check({nm, " model pin"}, m_prod, exp);
  endtask

  initial begin
    int nb, t1, t2, base_acc, base_done, n;

    // reset held 2 cycles, then idle
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("idle busy", {15'd0, busy}, 16'd0);
    check("idle product", product, 16'h0000);

    op(8'h0D, 8'h0B, 16'h008F, "0Dx0B");
    op(8'hFF, 8'hFF, 16'hFE01, "FFxFF");

    // mid-run start ignored, reset aborts with no done
    @(negedge clk);
    start = 1; multiplicand = 8'h12; multiplier = 8'h34;
    @(negedge clk);                 // RUN cycle 1
    start = 0;
    @(negedge clk);                 // RUN cycle 2
    @(negedge clk);                 // RUN cycle 3
    start = 1; multiplicand = 8'h01; multiplier = 8'h01;
    @(negedge clk);                 // RUN cycle 4
    start = 0;
    @(negedge clk);                 // RUN cycle 5
    check("mid-run still busy", {15'd0, busy}, 16'd1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("abort busy", {15'd0, busy}, 16'd0);
    check("abort product", product, 16'h0000);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) n++;
      @(negedge clk);
    end
    check("abort no done", 16'(n), 16'd0);
    op(8'h12, 8'h34, 16'h03A8, "12x34");

    // back-to-back through DONE
    @(negedge clk);
    start = 1; multiplicand = 8'h00; multiplier = 8'hFF;
    @(negedge clk);
    multiplicand = 8'hFF; multiplier = 8'h00;
    wait_done("b2b first", nb, t1);
    check("b2b first product", product, 16'h0000);
    @(negedge clk);
    start = 0;
    check("b2b busy reasserted", {15'd0, busy}, 16'd1);
    wait_done("b2b second", nb, t2);
    check("b2b spacing", 16'(t2 - t1), 16'd9);
    check("b2b second product", product, 16'h0000);

    // random sweep
    repeat (3) @(negedge clk);
    base_acc  = m_accepts;
    base_done = dut_dones;
    for (int i = 0; i < 30000 && (m_accepts - base_acc) < 1000; i++) begin
      @(negedge clk);
      start        = 1'($urandom_range(0, 1));
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
    end
    @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);
    check("random accepts", 16'(m_accepts - base_acc), 16'd1000);
    check("random done count", 16'(dut_dones - base_done), 16'(m_accepts - base_acc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
